// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per CALC cycle, signed or unsigned,
// fixed latency independent of operand values.
module seq_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign_en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned   CntW    = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StAdj, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic             sgn_q, sgn_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic             accept;
  logic [WIDTH-1:0] abs_dvd, abs_dvs;
  logic [WIDTH:0]   trial, diff;

  assign accept  = start & ready;
  assign abs_dvd = (sign_en && dividend[WIDTH-1]) ? -dividend : dividend;
  assign abs_dvs = (sign_en && divisor[WIDTH-1])  ? -divisor  : divisor;
  // One restoring step: a borrow out of the WIDTH+1 bit subtract means "keep".
  assign trial   = {prem_q, dvd_q[WIDTH-1]};
  assign diff    = trial - {1'b0, dvs_q};

  assign ready     = (state_q == StIdle) || (state_q == StDone);
  assign busy      = (state_q == StCalc) || (state_q == StAdj);
  assign done      = (state_q == StDone);
  assign quotient  = quo_q;
  assign remainder = rem_q;

  // Next-state and datapath update for every register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = StCalc;
          cnt_d   = '0;
          dvd_d   = abs_dvd;
          dvs_d   = abs_dvs;
          prem_d  = '0;
          sgn_d   = sign_en;
          qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rneg_d  = dividend[WIDTH-1];
          dz_d    = (divisor == '0);
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        cnt_d  = cnt_q + 1'b1;
        prem_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        dvd_d  = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
        if (cnt_q == CntLast) begin
          state_d = StAdj;
        end
      end
      StAdj: begin
        // Divide-by-zero keeps the all-ones quotient regardless of signs.
        quo_d   = (sgn_q && qneg_q && !dz_q) ? -dvd_q : dvd_q;
        rem_d   = (sgn_q && rneg_q) ? -prem_q : prem_q;
        state_d = StDone;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      prem_q <= '0;
      sgn_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      prem_q <= prem_d;
      sgn_q  <= sgn_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, corner sequences and
// randomized operations against an arithmetic reference model.
module tb_seq_divider;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sign_en;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W), .ITER(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sign_en   (sign_en),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Plain arithmetic reference: truncating division with the defined special cases.
  function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end
  endfunction

  // Present an operation; returns #1 after the accepting edge (first CALC cycle).
  task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    sign_en  = s;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    sign_en  = 1'($urandom);
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Wait for done while jiggling inputs and spurious starts; checks latency and holding.
  task automatic wait_done(input string tag);
    int lat = 1;
    bit busy_ok = 1'b1;
    bit held = 1'b1;
    while (done !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1 || ready !== 1'b0) busy_ok = 1'b0;
      if (quotient !== last_q || remainder !== last_r) held = 1'b0;
      if (lat <= 32) begin
        start    = (lat == 5) ? 1'b1 : 1'($urandom);
        sign_en  = 1'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, W'(lat), W'(LAT));
    check({tag, " busy_window"}, W'(busy_ok), W'(1));
    check({tag, " result_held"}, W'(held), W'(1));
  endtask

  task automatic do_op(input string tag, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er);
    launch(s, a, b);
    wait_done(tag);
    check({tag, " done"}, W'(done), W'(1));
    check({tag, " ready_in_done"}, W'(ready), W'(1));
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    last_q = eq;
    last_r = er;
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk);
    #1;
    check({tag, " done_pulse_end"}, W'(done), W'(0));
    check({tag, " idle_ready"}, W'(ready), W'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, b, eq, er;
    logic         s;
    bit           no_done;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE};
    vecs[2]  = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2};
    vecs[3]  = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
    vecs[4]  = '{1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
    vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[6]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
    vecs[7]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[8]  = '{1'b0, 32'd7,          32'd100,        32'd0,          32'd7};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF};
    vecs[10] = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0};
    vecs[11] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};

    start    = 1'b0;
    sign_en  = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst_n    = 1'b0;
    #2;
    check("reset ready", W'(ready), W'(1));
    check("reset busy", W'(busy), W'(0));
    check("reset done", W'(done), W'(0));
    check("reset quotient", quotient, '0);
    check("reset remainder", remainder, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);
      idle_check($sformatf("vec%0d", i));
    end

    // Back-to-back: start held in DONE, second op finishes 68 cycles after the first start.
    do_op("b2b_first", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    do_op("b2b_second", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    idle_check("b2b");

    // Reset in the middle of an operation.
    launch(1'b0, 32'd1000, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst quotient", quotient, '0);
    check("midrst remainder", remainder, '0);
    check("midrst busy", W'(busy), W'(0));
    check("midrst ready", W'(ready), W'(1));
    check("midrst done", W'(done), W'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_q = '0;
    last_r = '0;
    no_done = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || ready !== 1'b1) no_done = 1'b0;
    end
    check("midrst no_done_after", W'(no_done), W'(1));
    do_op("after_rst", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1);
    idle_check("after_rst");

    // Randomized operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = '1;
        3: begin a = 32'h8000_0000; b = $urandom; end
        4: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      model(s, a, b, eq, er);
      do_op($sformatf("rand%0d", n), s, a, b, eq, er);
      if ($urandom_range(0, 3) != 0) idle_check($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter ITER, default WIDTH, meaning the number of CALC-state iteration cycles (one quotient bit per cycle).
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port start  input  1  request; operands sampled on the rising edge where start=1 and ready=1.
REQ-006 The block SHALL have port sign_en  input  1  signed (two's-complement) divide when 1, unsigned when 0; sampled with the operands.
REQ-007 The block SHALL have port dividend  input  WIDTH  numerator.
REQ-008 The block SHALL have port divisor  input  WIDTH  denominator.
REQ-009 The block SHALL have port ready  output  1  high in IDLE and DONE; the block accepts start only then.
REQ-010 The block SHALL have port busy  output  1  high in CALC and ADJ.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse in DONE.
REQ-012 The block SHALL have port quotient  output  WIDTH  registered result.
REQ-013 The block SHALL have port remainder  output  WIDTH  registered result.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, ADJ, DONE; IDLE->CALC on accepted start; CALC->ADJ after ITER cycles; ADJ->DONE; DONE->CALC if start=1, else DONE->IDLE.
REQ-015 Latency SHALL be fixed: start accepted at edge T -> CALC cycles T+1..T+ITER, ADJ at T+ITER+1, done=1 during cycle T+ITER+2 (34 cycles for WIDTH=32), independent of operand values.
REQ-016 On accept, the block SHALL latch the absolute values of dividend and divisor (absolute values only when sign_en=1), the sign_en value, the quotient sign (dividend MSB xor divisor MSB) and the remainder sign (dividend MSB).
REQ-017 Each CALC cycle SHALL perform one restoring step: partial remainder shifted left by 1 with the next dividend bit (MSB first); the latched divisor is subtracted in WIDTH+1 bits; if non-negative, the difference is kept and quotient bit 1 is shifted in, else the partial remainder is kept and 0 is shifted in.
REQ-018 ADJ SHALL negate the quotient if signed and the quotient sign is 1, negate the remainder if signed and the remainder sign is 1, then register quotient/remainder.
REQ-019 Results SHALL satisfy dividend = quotient*divisor + remainder (mod 2^WIDTH), |remainder| < |divisor|, with truncation toward zero.
REQ-020 When divisor=0, the result SHALL be quotient = all ones and remainder = dividend, for both signed and unsigned, with the same latency.
REQ-021 For a signed overflow (dividend = most-negative value, divisor = -1), the result SHALL be quotient = most-negative value and remainder = 0.
REQ-022 quotient/remainder SHALL hold the last result from DONE until the ADJ of the next operation, and SHALL NOT change during CALC.
REQ-023 start while busy=1 SHALL be ignored; operand/sign_en changes while busy SHALL NOT affect the result.
REQ-024 start=1 in DONE SHALL be accepted in that cycle (back-to-back), with done still pulsing for the finishing operation.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, ready=1, busy=0, done=0, quotient=0, remainder=0, iteration counter=0, asynchronously.
REQ-026 Reset asserted mid-operation SHALL abort the operation; no done pulse follows, and the block is ready one cycle after rst_n deasserts.

Verification
REQ-027 Unsigned 100/7, start at T -> done at T+34 with quotient=14, remainder=2; busy high T+1..T+33.
REQ-028 Signed -100/7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2); signed 100/-7 -> quotient -14, remainder 2.
REQ-029 Divide by zero, 0x12345678/0 (signed and unsigned) -> quotient=0xFFFFFFFF, remainder=0x12345678 at T+34.
REQ-030 Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned same operands -> quotient=0, remainder=0x80000000.
REQ-031 start pulsed again at T+5 with new operands -> ignored, first result unchanged; start held high in DONE -> second operation's done at T+68.
REQ-032 rst_n pulled low at T+10 of an operation -> outputs zero immediately, no done pulse; a new start after release completes correctly.
